// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Memory-access stage of the RV32I core. Accepts a load/store request from the
// execute stage, runs one access on a word-wide request/ready data bus, and
// returns sign/zero-extended load data. Misaligned requests complete with an
// error and never reach the bus. An optional timeout aborts a request that the
// bus never accepts.
//
// Parameters
//   TIMEOUT         ACCESS cycles without mem_ready before the request is
//                   aborted; 0 disables the timeout
//
// Ports
//   clk             clock, all state on rising edge
//   rst_n           asynchronous active-low reset
//   start           request from execute stage, sampled only in IDLE
//   alucode [5:0]   operation (ALU_* encoding, see localparams below)
//   addr [31:0]     effective address
//   store_data      rs2 value for stores
//   busy            high in every state except IDLE
//   done            one-cycle completion pulse
//   load_data       extended load result, valid with done, held until next done
//   err_misaligned  misaligned access, valid with done
//   err_timeout     bus timeout, valid with done
//   mem_req         bus request, held until mem_ready
//   mem_we          1 = write
//   mem_addr        word address {addr[31:2],2'b00}
//   mem_wstrb       byte-lane write enables, 0 for reads
//   mem_wdata       lane-replicated write data
//   mem_ready       bus accepts/completes the request this cycle
//   mem_rdata       read word, valid with mem_ready on reads
// -----------------------------------------------------------------------------
module load_store_unit #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [5:0]  alucode,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        busy,
   output logic        done,
   output logic [31:0] load_data,
   output logic        err_misaligned,
   output logic        err_timeout,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);

   // Load/store alucodes; these values must match the core's ALU encoding.
   localparam logic [5:0] ALU_LB  = 6'h10;
   localparam logic [5:0] ALU_LH  = 6'h11;
   localparam logic [5:0] ALU_LW  = 6'h12;
   localparam logic [5:0] ALU_LBU = 6'h13;
   localparam logic [5:0] ALU_LHU = 6'h14;
   localparam logic [5:0] ALU_SB  = 6'h15;
   localparam logic [5:0] ALU_SH  = 6'h16;
   localparam logic [5:0] ALU_SW  = 6'h17;

   localparam int             CW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_FINISH = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_next;

   logic [5:0]    r_op;
   logic [1:0]    r_addr_lo;
   logic          r_is_load;
   logic          r_misaligned;
   logic [CW-1:0] r_cnt;
   logic          r_mem_we;
   logic [31:0]   r_mem_addr;
   logic [3:0]    r_mem_wstrb;
   logic [31:0]   r_mem_wdata;
   logic [31:0]   r_load_data;
   logic          r_err_mis;
   logic          r_err_to;

   logic          w_is_load;
   logic          w_is_store;
   logic          w_mis;
   logic [3:0]    w_wstrb;
   logic [31:0]   w_wdata;
   logic          w_accept;
   logic          w_timeout;
   logic [7:0]    w_byte;
   logic [15:0]   w_half;
   logic [31:0]   w_fmt;

   // ---------------------------------------------------------------------------
   // Request decode: classify the alucode, check alignment, format write data
   // ---------------------------------------------------------------------------
   always_comb begin
      w_is_load  = 1'b0;
      w_is_store = 1'b0;
      w_mis      = 1'b0;
      w_wstrb    = 4'b0000;
      w_wdata    = 32'h0;
      case (alucode)
         ALU_LB, ALU_LBU: w_is_load = 1'b1;
         ALU_LH, ALU_LHU: begin
            w_is_load = 1'b1;
            w_mis     = addr[0];
         end
         ALU_LW: begin
            w_is_load = 1'b1;
            w_mis     = |addr[1:0];
         end
         ALU_SB: begin
            w_is_store = 1'b1;
            w_wstrb    = 4'b0001 << addr[1:0];
            w_wdata    = {4{store_data[7:0]}};
         end
         ALU_SH: begin
            w_is_store = 1'b1;
            w_mis      = addr[0];
            w_wstrb    = addr[1] ? 4'b1100 : 4'b0011;
            w_wdata    = {2{store_data[15:0]}};
         end
         ALU_SW: begin
            w_is_store = 1'b1;
            w_mis      = |addr[1:0];
            w_wstrb    = 4'b1111;
            w_wdata    = store_data;
         end
         default: ;
      endcase
   end

   assign w_accept = (r_state == S_IDLE) && start && (w_is_load || w_is_store);

   // ---------------------------------------------------------------------------
   // Read formatting from the latched op and low address bits
   // ---------------------------------------------------------------------------
   always_comb begin
      w_byte = 8'h0;
      case (r_addr_lo)
         2'd0: w_byte = mem_rdata[7:0];
         2'd1: w_byte = mem_rdata[15:8];
         2'd2: w_byte = mem_rdata[23:16];
         2'd3: w_byte = mem_rdata[31:24];
         default: ;
      endcase
      w_half = r_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      w_fmt  = 32'h0;
      case (r_op)
         ALU_LB:  w_fmt = {{24{w_byte[7]}}, w_byte};
         ALU_LBU: w_fmt = {24'h0, w_byte};
         ALU_LH:  w_fmt = {{16{w_half[15]}}, w_half};
         ALU_LHU: w_fmt = {16'h0, w_half};
         ALU_LW:  w_fmt = mem_rdata;
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM next state
   // A misaligned request also passes through ACCESS, with mem_req held low,
   // so that every completion takes the same two cycles from start to done.
   // ---------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_timeout    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_state_next = S_ACCESS;
         end
         S_ACCESS: begin
            if (r_misaligned || mem_ready) begin
               w_state_next = S_FINISH;
            end else if ((TIMEOUT != 0) && (r_cnt == CNT_LAST)) begin
               // This cycle is the TIMEOUT-th one without mem_ready.
               w_state_next = S_FINISH;
               w_timeout    = 1'b1;
            end
         end
         S_FINISH: w_state_next = S_IDLE;
         default:  w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   // ---------------------------------------------------------------------------
   // Request latches, bus registers, timeout counter, completion results
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op         <= 6'h0;
         r_addr_lo    <= 2'b00;
         r_is_load    <= 1'b0;
         r_misaligned <= 1'b0;
         r_cnt        <= '0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= 32'h0;
         r_mem_wstrb  <= 4'b0000;
         r_mem_wdata  <= 32'h0;
         r_load_data  <= 32'h0;
         r_err_mis    <= 1'b0;
         r_err_to     <= 1'b0;
      end else begin
         if (w_accept) begin
            r_op         <= alucode;
            r_addr_lo    <= addr[1:0];
            r_is_load    <= w_is_load;
            r_misaligned <= w_mis;
            r_cnt        <= '0;
            // Bus outputs only change for requests that will reach the bus.
            if (!w_mis) begin
               r_mem_we    <= w_is_store;
               r_mem_addr  <= {addr[31:2], 2'b00};
               r_mem_wstrb <= w_wstrb;
               r_mem_wdata <= w_wdata;
            end
         end

         if ((r_state == S_ACCESS) && !r_misaligned && !mem_ready && (TIMEOUT != 0))
            r_cnt <= r_cnt + 1'b1;

         if ((r_state == S_ACCESS) && (w_state_next == S_FINISH)) begin
            r_err_mis   <= r_misaligned;
            r_err_to    <= w_timeout;
            // Stores and error completions report zero.
            r_load_data <= (!r_misaligned && mem_ready && r_is_load) ? w_fmt : 32'h0;
         end

         if (r_state == S_FINISH) begin
            r_err_mis <= 1'b0;
            r_err_to  <= 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs; mem_req is decoded from state so reset removes it immediately
   // ---------------------------------------------------------------------------
   assign busy           = (r_state != S_IDLE);
   assign done           = (r_state == S_FINISH);
   assign mem_req        = (r_state == S_ACCESS) && !r_misaligned;
   assign mem_we         = r_mem_we;
   assign mem_addr       = r_mem_addr;
   assign mem_wstrb      = r_mem_wstrb;
   assign mem_wdata      = r_mem_wdata;
   assign load_data      = r_load_data;
   assign err_misaligned = r_err_mis;
   assign err_timeout    = r_err_to;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Directed bench for load_store_unit. Main instance uses TIMEOUT=16; a second
// instance with TIMEOUT=4 and mem_ready tied low covers the bus timeout.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

   localparam logic [5:0] ALU_ADD = 6'h00;
   localparam logic [5:0] ALU_LB  = 6'h10;
   localparam logic [5:0] ALU_LH  = 6'h11;
   localparam logic [5:0] ALU_LW  = 6'h12;
   localparam logic [5:0] ALU_LBU = 6'h13;
   localparam logic [5:0] ALU_SH  = 6'h16;
   localparam logic [5:0] ALU_SW  = 6'h17;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        start_t;
   logic [5:0]  alucode;
   logic [31:0] addr;
   logic [31:0] store_data;
   logic        mem_ready;
   logic        mem_ready_t;
   logic [31:0] mem_rdata;

   logic        busy, done, err_misaligned, err_timeout, mem_req, mem_we;
   logic [31:0] load_data, mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;

   logic        busy_t, done_t, err_mis_t, err_to_t, mem_req_t, mem_we_t;
   logic [31:0] load_data_t, mem_addr_t, mem_wdata_t;
   logic [3:0]  mem_wstrb_t;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   load_store_unit #(.TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .alucode(alucode), .addr(addr),
      .store_data(store_data), .busy(busy), .done(done), .load_data(load_data),
      .err_misaligned(err_misaligned), .err_timeout(err_timeout),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   load_store_unit #(.TIMEOUT(4)) dut_t (
      .clk(clk), .rst_n(rst_n), .start(start_t), .alucode(alucode), .addr(addr),
      .store_data(store_data), .busy(busy_t), .done(done_t), .load_data(load_data_t),
      .err_misaligned(err_mis_t), .err_timeout(err_to_t),
      .mem_req(mem_req_t), .mem_we(mem_we_t), .mem_addr(mem_addr_t),
      .mem_wstrb(mem_wstrb_t), .mem_wdata(mem_wdata_t),
      .mem_ready(mem_ready_t), .mem_rdata(mem_rdata)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
      start      = 1'b1;
      alucode    = op;
      addr       = a;
      store_data = d;
   endtask

   initial begin
      rst_n       = 1'b0;
      start       = 1'b0;
      start_t     = 1'b0;
      alucode     = ALU_ADD;
      addr        = 32'h0;
      store_data  = 32'h0;
      mem_ready   = 1'b0;
      mem_ready_t = 1'b0;
      mem_rdata   = 32'h0;

      // Reset state
      tick();
      tick();
      check("rst_busy", {31'h0, busy}, 32'd0);
      check("rst_done", {31'h0, done}, 32'd0);
      check("rst_req", {31'h0, mem_req}, 32'd0);
      check("rst_we", {31'h0, mem_we}, 32'd0);
      check("rst_wstrb", {28'h0, mem_wstrb}, 32'd0);
      check("rst_load_data", load_data, 32'h0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_wdata", mem_wdata, 32'h0);
      check("rst_errs", {30'h0, err_misaligned, err_timeout}, 32'd0);
      rst_n = 1'b1;
      tick();

      // LB 0x103, ready on first ACCESS cycle
      issue(ALU_LB, 32'h0000_0103, 32'h0);
      mem_ready = 1'b1;
      mem_rdata = 32'h8011_2233;
      tick();
      start = 1'b0;
      check("lb_req", {31'h0, mem_req}, 32'd1);
      check("lb_addr", mem_addr, 32'h0000_0100);
      check("lb_wstrb", {28'h0, mem_wstrb}, 32'd0);
      check("lb_we", {31'h0, mem_we}, 32'd0);
      check("lb_busy", {31'h0, busy}, 32'd1);
      check("lb_done_early", {31'h0, done}, 32'd0);
      tick();
      check("lb_done", {31'h0, done}, 32'd1);
      check("lb_data", load_data, 32'hFFFF_FF80);
      check("lb_errs", {30'h0, err_misaligned, err_timeout}, 32'd0);
      check("lb_req_off", {31'h0, mem_req}, 32'd0);
      tick();
      check("lb_done_pulse", {31'h0, done}, 32'd0);
      check("lb_idle", {31'h0, busy}, 32'd0);
      check("lb_data_held", load_data, 32'hFFFF_FF80);

      // LBU, same access
      issue(ALU_LBU, 32'h0000_0103, 32'h0);
      tick();
      start = 1'b0;
      check("lbu_req", {31'h0, mem_req}, 32'd1);
      tick();
      check("lbu_done", {31'h0, done}, 32'd1);
      check("lbu_data", load_data, 32'h0000_0080);
      tick();

      // SH 0x202
      issue(ALU_SH, 32'h0000_0202, 32'hDEAD_BEEF);
      tick();
      start = 1'b0;
      check("sh_req", {31'h0, mem_req}, 32'd1);
      check("sh_we", {31'h0, mem_we}, 32'd1);
      check("sh_addr", mem_addr, 32'h0000_0200);
      check("sh_wstrb", {28'h0, mem_wstrb}, 32'h0000_000C);
      check("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
      tick();
      check("sh_done", {31'h0, done}, 32'd1);
      check("sh_errs", {30'h0, err_misaligned, err_timeout}, 32'd0);
      check("sh_load_data", load_data, 32'h0);
      tick();

      // Misaligned LW 0x301 (ready high to show it is never used)
      issue(ALU_LW, 32'h0000_0301, 32'h0);
      tick();
      start = 1'b0;
      check("mlw_no_req", {31'h0, mem_req}, 32'd0);
      check("mlw_busy", {31'h0, busy}, 32'd1);
      check("mlw_done_early", {31'h0, done}, 32'd0);
      tick();
      check("mlw_done", {31'h0, done}, 32'd1);
      check("mlw_errs", {30'h0, err_misaligned, err_timeout}, 32'd2);
      check("mlw_no_req2", {31'h0, mem_req}, 32'd0);
      check("mlw_data", load_data, 32'h0);
      tick();
      check("mlw_err_clr", {30'h0, err_misaligned, err_timeout}, 32'd0);

      // Misaligned SH 0x1
      issue(ALU_SH, 32'h0000_0001, 32'h1234_5678);
      tick();
      start = 1'b0;
      check("msh_no_req", {31'h0, mem_req}, 32'd0);
      tick();
      check("msh_done", {31'h0, done}, 32'd1);
      check("msh_errs", {30'h0, err_misaligned, err_timeout}, 32'd2);
      check("msh_data", load_data, 32'h0);
      tick();

      // Non load/store alucode: ignored
      issue(ALU_ADD, 32'h0000_0010, 32'h0);
      tick();
      start = 1'b0;
      check("ign_busy", {31'h0, busy}, 32'd0);
      check("ign_req", {31'h0, mem_req}, 32'd0);
      tick();
      check("ign_done", {31'h0, done}, 32'd0);

      // LH 0x402 with mem_ready delayed, start pulses during access ignored
      mem_ready = 1'b0;
      mem_rdata = 32'h7FFF_1234;
      issue(ALU_LH, 32'h0000_0402, 32'h0);
      tick();
      for (int k = 1; k <= 5; k++) begin
         check($sformatf("lh_wait%0d_req", k), {31'h0, mem_req}, 32'd1);
         check($sformatf("lh_wait%0d_addr", k), mem_addr, 32'h0000_0400);
         check($sformatf("lh_wait%0d_done", k), {31'h0, done}, 32'd0);
         start   = (k % 2 == 1);
         alucode = ALU_SW;
         addr    = 32'h0000_0900;
         tick();
      end
      start = 1'b0;
      check("lh_c6_req", {31'h0, mem_req}, 32'd1);
      check("lh_c6_addr", mem_addr, 32'h0000_0400);
      check("lh_c6_we", {31'h0, mem_we}, 32'd0);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      check("lh_done", {31'h0, done}, 32'd1);
      check("lh_data", load_data, 32'h0000_7FFF);
      tick();
      check("lh_idle", {31'h0, busy}, 32'd0);
      tick();
      check("lh_not_queued", {31'h0, busy}, 32'd0);

      // Timeout instance: TIMEOUT=4, mem_ready tied low
      start_t = 1'b1;
      alucode = ALU_LW;
      addr    = 32'h0000_0700;
      tick();
      start_t = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         check($sformatf("to_c%0d_req", k), {31'h0, mem_req_t}, 32'd1);
         check($sformatf("to_c%0d_done", k), {31'h0, done_t}, 32'd0);
         tick();
      end
      check("to_req_dropped", {31'h0, mem_req_t}, 32'd0);
      check("to_done", {31'h0, done_t}, 32'd1);
      check("to_errs", {30'h0, err_mis_t, err_to_t}, 32'd1);
      check("to_data", load_data_t, 32'h0);
      tick();
      check("to_done_pulse", {31'h0, done_t}, 32'd0);
      check("to_err_clr", {30'h0, err_mis_t, err_to_t}, 32'd0);

      // Reset during SW access
      issue(ALU_SW, 32'h0000_0500, 32'h1122_3344);
      tick();
      start = 1'b0;
      check("sw_req", {31'h0, mem_req}, 32'd1);
      check("sw_wstrb", {28'h0, mem_wstrb}, 32'h0000_000F);
      check("sw_wdata", mem_wdata, 32'h1122_3344);
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_req", {31'h0, mem_req}, 32'd0);
      check("arst_busy", {31'h0, busy}, 32'd0);
      check("arst_wstrb", {28'h0, mem_wstrb}, 32'd0);
      mem_ready = 1'b1;
      tick();
      check("arst_no_done1", {31'h0, done}, 32'd0);
      tick();
      check("arst_no_done2", {31'h0, done}, 32'd0);
      rst_n = 1'b1;
      tick();
      check("arst_after_idle", {31'h0, busy}, 32'd0);

      // New LW after reset
      mem_rdata = 32'hCAFE_F00D;
      issue(ALU_LW, 32'h0000_0600, 32'h0);
      tick();
      start = 1'b0;
      check("lw_req", {31'h0, mem_req}, 32'd1);
      check("lw_addr", mem_addr, 32'h0000_0600);
      check("lw_wstrb", {28'h0, mem_wstrb}, 32'd0);
      tick();
      check("lw_done", {31'h0, done}, 32'd1);
      check("lw_data", load_data, 32'hCAFE_F00D);
      check("lw_errs", {30'h0, err_misaligned, err_timeout}, 32'd0);
      mem_ready = 1'b0;
      tick();
      check("lw_idle", {31'h0, busy}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
